// File: rtl/rvx_ring_request_initiator.sv
// Ring request initiator: injects a one-beat request packet into the ring, then waits for
// the matching response (or a timeout). All other ring traffic passes straight through.
module rvx_ring_request_initiator #(
    parameter int                        HEADER_WIDTH    = 8,
    parameter int                        PAYLOAD_WIDTH   = 32,
    parameter int                        TARGET_ID_WIDTH = 4,
    parameter logic [HEADER_WIDTH-1:0]   REQ_HEADER      = 8'hA1,
    parameter logic [HEADER_WIDTH-1:0]   RSP_HEADER      = 8'hA2,
    parameter int unsigned               TIMEOUT_CYCLES  = 255
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      rx_valid,
    input  logic [HEADER_WIDTH+PAYLOAD_WIDTH-1:0]     rx_data,
    output logic                                      rx_ready,
    output logic                                      tx_valid,
    output logic [HEADER_WIDTH+PAYLOAD_WIDTH-1:0]     tx_data,
    input  logic                                      tx_ready,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [TARGET_ID_WIDTH-1:0]                req_target,
    input  logic [PAYLOAD_WIDTH-TARGET_ID_WIDTH-1:0]  req_data,
    output logic                                      rsp_valid,
    output logic [PAYLOAD_WIDTH-TARGET_ID_WIDTH-1:0]  rsp_data,
    output logic                                      rsp_timeout,
    input  logic                                      rsp_ready,
    output logic [1:0]                                state_dbg
);

    localparam int          PKT_W      = HEADER_WIDTH + PAYLOAD_WIDTH;
    localparam int          DATA_W     = PAYLOAD_WIDTH - TARGET_ID_WIDTH;
    localparam int          CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LIMIT      = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [PKT_W-1:0] pkt;
    logic [CNT_W-1:0] cnt;
    logic             rsp_hit;

    // Handshake: a beat moves on any cycle where valid and ready are both high;
    // a producer keeps valid (and its data) steady until that cycle.
    assign rsp_hit   = rx_valid && (rx_data[PKT_W-1 -: HEADER_WIDTH] == RSP_HEADER);
    assign state_dbg = state;
    assign req_ready = !rst && (state == S_IDLE);
    assign rsp_valid = !rst && (state == S_DONE);

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = rx_data;
        rx_ready = 1'b0;
        if (!rst) begin
            case (state)
                S_SEND: begin
                    tx_valid = 1'b1;
                    tx_data  = pkt;
                end
                S_WAIT: begin
                    // A response is swallowed here and never reaches tx.
                    if (rsp_hit) begin
                        rx_ready = 1'b1;
                    end else begin
                        tx_valid = rx_valid;
                        rx_ready = tx_ready;
                    end
                end
                default: begin
                    tx_valid = rx_valid;
                    rx_ready = tx_ready;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pkt         <= '0;
            cnt         <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        pkt   <= {REQ_HEADER, req_target, req_data};
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    cnt <= '0;
                    if (tx_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (rsp_hit) begin
                        rsp_data    <= rx_data[DATA_W-1:0];
                        rsp_timeout <= 1'b0;
                        state       <= S_DONE;
                    end else if (TIMEOUT_EN && (cnt == LIMIT_C)) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                default: begin
                    if (rsp_ready) state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
